fp_add_arbiter: RTL and testbench
=================================

# fp_add_arbiter

Round-robin arbiter and sequencer that shares one combinational FP32 adder (`ADD`, ports `FP_A`, `FP_B`, `FP_out`) among several requesters in the RNN accelerator datapath. It serves gate-accumulation units, bias-add logic and similar clients that each need occasional single-precision additions. It grants one requester at a time and registers that requester's operands into the adder. It returns the registered sum with the requester's ID over a valid/ready response channel.

## Interface
- `N_REQ`, 4: number of requesters (2..8); the ID width is `IDW = $clog2(N_REQ)`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  N_REQ  per-requester request valid.
- `req_a`  in  32*N_REQ  operand A, IEEE-754 single; requester i occupies bits [32i+31:32i].
- `req_b`  in  32*N_REQ  operand B, same packing.
- `req_ready`  out  N_REQ  per-requester accept; at most one bit high.
- `rsp_valid`  out  1  result valid.
- `rsp_id`  out  IDW  index of the requester that owns the result.
- `rsp_data`  out  32  FP32 sum A+B as produced by `ADD`.
- `rsp_ready`  in  1  consumer accepts the result.
- `busy`  out  1  high in any state other than IDLE.

## Operation
- There is one internal `ADD` instance, driven only from the registered operands `op_a` and `op_b`.
- The FSM has three states: IDLE, CALC and RESP.
- **IDLE**
  - `req_ready` is combinational. The arbiter searches from `ptr` upward, wrapping modulo N_REQ. The first i with `req_valid[i]` is granted, and `req_ready[i]` is set to 1.
  - On the edge where `req_valid[g]` and `req_ready[g]` are both high: capture `op_a<=req_a[g]`, `op_b<=req_b[g]`, `id<=g`, set `ptr<=(g+1) mod N_REQ`, and go to CALC.
  - With no valid request, stay in IDLE and hold `ptr`.
- **CALC**
  - `req_ready` is all zero.
  - On the edge, `rsp_data<=FP_out`, `rsp_id<=id`, `rsp_valid<=1`, and the FSM goes to RESP.
- **RESP**
  - `rsp_valid`, `rsp_id` and `rsp_data` stay stable until the edge where `rsp_valid&&rsp_ready`.
  - On that edge, `rsp_valid<=0` and the FSM goes to IDLE.
  - `req_ready` stays zero throughout RESP.
- `ptr` changes only on a grant. A requester that holds `req_valid` high therefore waits at most N_REQ-1 other grants.
- Operands pass through unmodified. Rounding, NaN, infinity and denormal handling are whatever `ADD` produces; this block only sequences.
- Requesters must keep `req_a`, `req_b` and `req_valid` stable until accepted. A requester that drops `req_valid` before acceptance is simply skipped.

## Timing
- **Reset:** asynchronous clear when `rst_n=0`. Every output is 0: `req_ready` (forced 0 during reset), `rsp_valid`, `rsp_id`, `rsp_data` and `busy`. State returns to IDLE and `ptr` to 0.
- **Reset mid-operation:** any in-flight transaction is discarded and no response is emitted. The requester must re-present the request.
- **Latency:** an accept on edge T gives CALC during cycle T..T+1. `rsp_valid` goes high after edge T+1 and is first sampled by the consumer at edge T+2.
- **Minimum request-to-request spacing:** 3 cycles (accept, calc, response accepted with `rsp_ready` already high).
- **Simultaneous events:** a response handshake and a new request in the same cycle are not overlapped. The new grant is made only once the FSM is back in IDLE, on the cycle after the response handshake.
- Only one transaction is outstanding at a time. There is no buffering beyond `op_a`/`op_b` and the response register.

## Test plan
- **Reset:** assert `rst_n=0` with all `req_valid=1` → all outputs 0, `req_ready=0`. Release → `req_ready=4'b0001` in the first IDLE cycle.
- **Single request:** req1 with `req_a=0x3F800000`, `req_b=0x40000000` → after accept at edge T, `rsp_valid=1` at T+2 with `rsp_id=1`, `rsp_data=0x40400000`, and `busy=1` until the response handshake.
- **Negative operands:** req0 with `0xBFA8F5C3` + `0xC0228F5C` (−1.32 + −2.54) → `rsp_data=0xC0770A3D`, `rsp_id=0`.
- **Round-robin:** all four requesters valid at once, with `rsp_ready=1` throughout → responses return in ID order 0,1,2,3. Requester 0 then presents a new request while 2 and 3 remain valid → next grants are 0 then 2 then 3, with `ptr` wrapping correctly.
- **Backpressure:** hold `rsp_ready=0` for 5 cycles during RESP → `rsp_valid`/`rsp_id`/`rsp_data` stay stable and `req_ready` stays 0. Raise `rsp_ready` → FSM returns to IDLE next cycle and the next grant follows.
- **Reset in CALC:** pulse `rst_n` low for 1 cycle in CALC → no `rsp_valid` for that request, `ptr=0`. The re-presented request then completes with the correct sum.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that time-shares one combinational FP32 adder among N_REQ requesters.
// One transaction in flight: accept -> registered operands -> registered sum -> valid/ready response.

// Combinational IEEE-754 single-precision adder, round-toward-zero, denormals supported.
module ADD (
    input  logic [31:0] FP_A,
    input  logic [31:0] FP_B,
    output logic [31:0] FP_out
);
    localparam int unsigned MW = 27;

    logic          swap;
    logic [31:0]   x;
    logic [31:0]   y;
    logic [7:0]    ex_eff;
    logic [7:0]    ey_eff;
    logic [7:0]    d;
    logic [MW-1:0] mx;
    logic [MW-1:0] my;
    logic [MW-1:0] my_sh;
    logic [MW-1:0] mask;
    logic          sticky;
    logic [MW:0]   sum;
    logic [MW-1:0] norm;
    logic [8:0]    e;
    logic [4:0]    lz;
    logic [8:0]    sh;
    logic          x_nan;
    logic          y_nan;
    logic          x_inf;
    logic          y_inf;

    always_comb begin
        // x always holds the larger magnitude, so the result takes its sign
        swap   = FP_B[30:0] > FP_A[30:0];
        x      = swap ? FP_B : FP_A;
        y      = swap ? FP_A : FP_B;
        ex_eff = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey_eff = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        mx     = {x[30:23] != 8'd0, x[22:0], 3'b000};
        my     = {y[30:23] != 8'd0, y[22:0], 3'b000};
        d      = ex_eff - ey_eff;
        mask   = '0;
        my_sh  = '0;
        sticky = 1'b0;
        if (d >= 8'(MW)) begin
            sticky = |my;
        end else begin
            my_sh  = my >> d;
            mask   = (MW'(1) << d) - MW'(1);
            sticky = |(my & mask);
        end
        my_sh[0] = my_sh[0] | sticky;

        if (x[31] == y[31]) sum = {1'b0, mx} + {1'b0, my_sh};
        else                sum = {1'b0, mx} - {1'b0, my_sh};

        e    = {1'b0, ex_eff};
        norm = sum[MW-1:0];
        lz   = 5'd0;
        sh   = 9'd0;
        if (sum[MW]) begin
            norm = {sum[MW:2], sum[1] | sum[0]};
            e    = e + 9'd1;
        end else begin
            // normalise left, but never below the denormal exponent
            lz = 5'(MW);
            for (int i = 0; i < int'(MW); i++) begin
                if (sum[i]) lz = 5'(int'(MW) - 1 - i);
            end
            sh   = ({4'd0, lz} > (e - 9'd1)) ? (e - 9'd1) : {4'd0, lz};
            norm = sum[MW-1:0] << sh;
            e    = e - sh;
        end

        x_nan = (x[30:23] == 8'hFF) && (x[22:0] != 23'd0);
        y_nan = (y[30:23] == 8'hFF) && (y[22:0] != 23'd0);
        x_inf = (x[30:23] == 8'hFF) && (x[22:0] == 23'd0);
        y_inf = (y[30:23] == 8'hFF) && (y[22:0] == 23'd0);

        FP_out = 32'd0;
        if (x_nan || y_nan || (x_inf && y_inf && (x[31] != y[31]))) begin
            FP_out = 32'h7FC0_0000;
        end else if (x_inf) begin
            FP_out = x;
        end else if (sum == '0) begin
            FP_out = {x[31] & y[31], 31'd0};
        end else if (e >= 9'd255) begin
            FP_out = {x[31], 31'h7F7F_FFFF};
        end else begin
            FP_out = {x[31], norm[MW-1] ? e[7:0] : 8'd0, norm[MW-2:3]};
        end
    end
endmodule

module fp_add_arbiter #(
    parameter  int unsigned N_REQ = 4,
    localparam int unsigned IDW   = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [32*N_REQ-1:0] req_a,
    input  logic [32*N_REQ-1:0] req_b,
    output logic [N_REQ-1:0]    req_ready,
    output logic                rsp_valid,
    output logic [IDW-1:0]      rsp_id,
    output logic [31:0]         rsp_data,
    input  logic                rsp_ready,
    output logic                busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] id;
    logic [IDW-1:0] gnt;
    logic [IDW:0]   cand;
    logic           found;
    logic           accept;
    logic [31:0]    op_a;
    logic [31:0]    op_b;
    logic [31:0]    fp_sum;
    logic [31:0]    a_arr [N_REQ];
    logic [31:0]    b_arr [N_REQ];

    ADD u_add (
        .FP_A   (op_a),
        .FP_B   (op_b),
        .FP_out (fp_sum)
    );

    always_comb begin
        for (int i = 0; i < int'(N_REQ); i++) begin
            a_arr[i] = req_a[32*i +: 32];
            b_arr[i] = req_b[32*i +: 32];
        end
    end

    // Search from ptr upward, wrapping; first valid requester wins
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        cand  = '0;
        for (int k = 0; k < int'(N_REQ); k++) begin
            cand = {1'b0, ptr} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(N_REQ)) cand = cand - (IDW+1)'(N_REQ);
            if (!found && req_valid[cand[IDW-1:0]]) begin
                found = 1'b1;
                gnt   = cand[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        req_ready  = '0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (rst_n && found) begin
                    req_ready[gnt] = 1'b1;
                    accept         = 1'b1;
                    state_next     = CALC;
                end
            end
            CALC:    state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            id        <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            busy      <= 1'b0;
        end else begin
            busy <= (state_next != IDLE);
            if (accept) begin
                op_a <= a_arr[gnt];
                op_b <= b_arr[gnt];
                id   <= gnt;
                ptr  <= (gnt == IDW'(N_REQ - 1)) ? '0 : gnt + IDW'(1);
            end
            if (state == CALC) begin
                rsp_valid <= 1'b1;
                rsp_id    <= id;
                rsp_data  <= fp_sum;
            end else if (state == RESP && rsp_ready) begin
                rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_add_arbiter.sv
// Directed bench for fp_add_arbiter: expected {id, sum} pairs are queued at issue time
// and a monitor pops and compares them on every response handshake.
module tb_fp_add_arbiter;
    localparam int unsigned N = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [32*N-1:0] req_a;
    logic [32*N-1:0] req_b;
    logic [N-1:0]   req_ready;
    logic           rsp_valid;
    logic [1:0]     rsp_id;
    logic [31:0]    rsp_data;
    logic           rsp_ready;
    logic           busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [33:0] sb [$];
    logic [N-1:0] acc;

    fp_add_arbiter #(.N_REQ(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_ready (rsp_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Advance one cycle; requesters drop valid right after being accepted
    task automatic tick();
        @(negedge clk);
        acc = req_ready & req_valid;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~acc;
    endtask

    task automatic issue(input int id, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] r, input bit push);
        req_a[32*id +: 32] = a;
        req_b[32*id +: 32] = b;
        req_valid[id]      = 1'b1;
        if (push) sb.push_back({2'(id), r});
    endtask

    task automatic wait_acc(input int id);
        bit got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            if (acc[id]) got = 1'b1;
        end
        chk($sformatf("accept_req%0d", id), 64'(got), 64'd1);
    endtask

    task automatic drain();
        bit done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            if (sb.size() == 0 && !busy && req_valid == '0) done = 1'b1;
        end
        chk("drain", 64'(done), 64'd1);
    endtask

    task automatic monitor();
        logic [33:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_rsp: got id %0d data %h, required no response",
                             rsp_id, rsp_data);
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id", 64'(rsp_id), 64'(e[33:32]));
                    chk("rsp_data", 64'(rsp_data), 64'(e[31:0]));
                end
            end
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = '1;
        req_a     = '0;
        req_b     = '0;
        acc       = '0;
        fork
            monitor();
        join_none

        // Reset with every requester valid
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rst_rsp_id", 64'(rsp_id), 64'd0);
        chk("rst_rsp_data", 64'(rsp_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("first_idle_ready", 64'(req_ready), 64'b0001);
        req_valid = '0;
        rsp_ready = 1'b1;

        // Single request: 1.0 + 2.0, latency and busy
        issue(1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        wait_acc(1);
        chk("calc_busy", 64'(busy), 64'd1);
        chk("calc_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("resp_valid", 64'(rsp_valid), 64'd1);
        chk("resp_id", 64'(rsp_id), 64'd1);
        chk("resp_data", 64'(rsp_data), 64'h4040_0000);
        chk("resp_busy", 64'(busy), 64'd1);
        tick();
        chk("post_hs_valid", 64'(rsp_valid), 64'd0);
        chk("post_hs_busy", 64'(busy), 64'd0);

        // Negative operands, then 1.5 + 0.25 from requester 3 to bring ptr back to 0
        issue(0, 32'hBFA8_F5C3, 32'hC022_8F5C, 32'hC077_0A3D, 1'b1);
        wait_acc(0);
        drain();
        issue(3, 32'h3FC0_0000, 32'h3E80_0000, 32'h3FE0_0000, 1'b1);
        wait_acc(3);
        drain();

        // All four valid: served 0,1,2,3
        issue(0, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b1);
        issue(1, 32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000, 1'b1);
        issue(2, 32'h4120_0000, 32'h3F00_0000, 32'h4128_0000, 1'b1);
        issue(3, 32'h3F80_0000, 32'h3380_0000, 32'h3F80_0000, 1'b1);
        drain();

        // ptr wrapped to 0: 0, 2, 3 served in that order
        issue(0, 32'hC040_0000, 32'h4040_0000, 32'h0000_0000, 1'b1);
        issue(2, 32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b1);
        issue(3, 32'h0000_0001, 32'h0000_0001, 32'h0000_0002, 1'b1);
        drain();

        // Backpressure: response held 5 cycles while requester 1 waits
        rsp_ready = 1'b0;
        issue(2, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 1'b1);
        wait_acc(2);
        tick();
        issue(1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b1);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_id", 64'(rsp_id), 64'd2);
            chk("bp_data", 64'(rsp_data), 64'h40E0_0000);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        chk("bp_release_valid", 64'(rsp_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_next_grant", 64'(req_ready), 64'b0010);
        wait_acc(1);
        drain();

        // Reset during CALC discards the transaction and resets ptr
        issue(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b0);
        wait_acc(1);
        chk("abort_in_calc", 64'(busy), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        issue(1, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1'b1);
        issue(2, 32'h4000_0000, 32'h3F80_0000, 32'h4040_0000, 1'b1);
        #1;
        chk("ptr_after_reset", 64'(req_ready), 64'b0010);
        drain();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
